// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline front end.
package arm_pipe_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      SKID = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [XLEN-1:0] NOP_INSTR    = 32'hE1A0_0000;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pcplus8;
   } ifid_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats enable; a bubble keeps the old PC+8.
module ifid_reg
   import arm_pipe_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en_i,
   input  logic  flush_i,
   input  logic  valid_i,
   input  ifid_t d_i,
   output ifid_t q_o,
   output logic  valid_o
);

   ifid_t data_q;
   logic  valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q.instr   <= NOP_INSTR;
         data_q.pcplus8 <= '0;
         valid_q        <= 1'b0;
      end else if (flush_i || en_i) begin
         if (!flush_i && valid_i) begin
            data_q  <= d_i;
            valid_q <= 1'b1;
         end else begin
            data_q.instr <= NOP_INSTR;
            valid_q      <= 1'b0;
         end
      end
   end

   assign q_o     = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, memory handshake FSM (RUN/SKID/DROP), skid buffer
// for words that arrive while decode is stalled, and redirect bookkeeping.
module fetch_stage
   import arm_pipe_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            BranchTakenE,
   input  logic [XLEN-1:0] ALUResultE,
   input  logic            PCSrcW,
   input  logic [XLEN-1:0] ResultW,
   output logic            ImemReq,
   output logic [XLEN-1:0] ImemAddr,
   input  logic            ImemAck,
   input  logic [XLEN-1:0] ImemRdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCPlus8D,
   output logic            ValidD,
   output logic            ImemWait
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   ifid_t           skid_q, skid_d;
   logic            req_q, req_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            ack;
   logic            deliver;
   ifid_t           ifid_d;
   ifid_t           ifid_q;

   assign redirect = BranchTakenE | PCSrcW;
   assign target   = word_align(BranchTakenE ? ALUResultE : ResultW);
   // An ack only counts while a request is actually on the bus.
   assign ack      = req_q & ImemAck;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      pend_d         = pend_q;
      skid_d         = skid_q;
      deliver        = 1'b0;
      ifid_d.instr   = ImemRdata;
      ifid_d.pcplus8 = pc_q + XLEN'(8);
      case (state_q)
         RUN: begin
            if (ack) begin
               if (redirect) begin
                  pc_d = target;
               end else begin
                  pc_d = pc_q + XLEN'(4);
                  if (StallD) begin
                     skid_d.instr   = ImemRdata;
                     skid_d.pcplus8 = pc_q + XLEN'(8);
                     state_d        = SKID;
                  end else begin
                     deliver = 1'b1;
                  end
               end
            end else if (req_q && redirect) begin
               pend_d  = target;
               state_d = DROP;
            end
         end
         SKID: begin
            if (redirect) begin
               pc_d    = target;
               state_d = RUN;
            end else if (!StallD) begin
               deliver = 1'b1;
               ifid_d  = skid_q;
               state_d = RUN;
            end
         end
         DROP: begin
            // The outstanding word is stale; the newest redirect wins.
            if (ack) begin
               pc_d    = redirect ? target : pend_q;
               state_d = RUN;
            end else if (redirect) begin
               pend_d = target;
            end
         end
         default: state_d = RUN;
      endcase
      req_d = (state_d != SKID);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
         skid_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         skid_q  <= skid_d;
         req_q   <= req_d;
      end
   end

   ifid_reg u_ifid (
      .clk     (clk),
      .rst_n   (reset),
      .en_i    (!StallD),
      .flush_i (FlushD),
      .valid_i (deliver),
      .d_i     (ifid_d),
      .q_o     (ifid_q),
      .valid_o (ValidD)
   );

   assign ImemReq  = req_q;
   assign ImemAddr = pc_q;
   assign InstrD   = ifid_q.instr;
   assign PCPlus8D = ifid_q.pcplus8;
   // Same-cycle view of the handshake so the hazard unit can stall this cycle.
   assign ImemWait = req_q & (((state_q == RUN) & ~ImemAck) | (state_q == DROP));

endmodule
